// File: rtl/bp_mmio_dword_serializer_if.sv
// Bundle of the io_cmd/io_resp and host-bridge word channels for the MMIO dword serializer.
// The slave modport is the serializer's view; master is the view of the surrounding core/bridge.
interface bp_mmio_dword_serializer_if #(
    parameter int addr_width_p = 40,
    parameter int hdr_width_p  = 16
);
    logic [hdr_width_p-1:0]  io_cmd_hdr_i;
    logic [addr_width_p-1:0] io_cmd_addr_i;
    logic [2:0]              io_cmd_size_i;
    logic [63:0]             io_cmd_data_i;
    logic                    io_cmd_v_i;
    logic                    io_cmd_ready_and_o;

    logic [hdr_width_p-1:0]  hb_cmd_hdr_o;
    logic [addr_width_p-1:0] hb_cmd_addr_o;
    logic [2:0]              hb_cmd_size_o;
    logic [31:0]             hb_cmd_data_o;
    logic                    hb_cmd_v_o;
    logic                    hb_cmd_ready_and_i;

    logic [hdr_width_p-1:0]  hb_resp_hdr_i;
    logic [addr_width_p-1:0] hb_resp_addr_i;
    logic [2:0]              hb_resp_size_i;
    logic [31:0]             hb_resp_data_i;
    logic                    hb_resp_v_i;
    logic                    hb_resp_yumi_o;

    logic [hdr_width_p-1:0]  io_resp_hdr_o;
    logic [addr_width_p-1:0] io_resp_addr_o;
    logic [2:0]              io_resp_size_o;
    logic [63:0]             io_resp_data_o;
    logic                    io_resp_v_o;
    logic                    io_resp_ready_and_i;

    modport slave (
        input  io_cmd_hdr_i, io_cmd_addr_i, io_cmd_size_i, io_cmd_data_i, io_cmd_v_i,
        output io_cmd_ready_and_o,
        output hb_cmd_hdr_o, hb_cmd_addr_o, hb_cmd_size_o, hb_cmd_data_o, hb_cmd_v_o,
        input  hb_cmd_ready_and_i,
        input  hb_resp_hdr_i, hb_resp_addr_i, hb_resp_size_i, hb_resp_data_i, hb_resp_v_i,
        output hb_resp_yumi_o,
        output io_resp_hdr_o, io_resp_addr_o, io_resp_size_o, io_resp_data_o, io_resp_v_o,
        input  io_resp_ready_and_i
    );

    modport master (
        output io_cmd_hdr_i, io_cmd_addr_i, io_cmd_size_i, io_cmd_data_i, io_cmd_v_i,
        input  io_cmd_ready_and_o,
        input  hb_cmd_hdr_o, hb_cmd_addr_o, hb_cmd_size_o, hb_cmd_data_o, hb_cmd_v_o,
        output hb_cmd_ready_and_i,
        output hb_resp_hdr_i, hb_resp_addr_i, hb_resp_size_i, hb_resp_data_i, hb_resp_v_i,
        input  hb_resp_yumi_o,
        input  io_resp_hdr_o, io_resp_addr_o, io_resp_size_o, io_resp_data_o, io_resp_v_o,
        output io_resp_ready_and_i
    );
endinterface

// File: rtl/bp_mmio_dword_serializer.sv
// Splits 8-byte io commands into two 4-byte bridge beats and merges the word responses back.
// Optional split-command counter (split_cnt_o) is built when BP_MMIO_SER_PERF_EN is defined.
module bp_mmio_dword_serializer #(
    parameter int addr_width_p      = 40,
    parameter int hdr_width_p       = 16,
    parameter int max_outstanding_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    bp_mmio_dword_serializer_if.slave bus
`ifdef BP_MMIO_SER_PERF_EN
    ,
    output logic [31:0] split_cnt_o
`endif
);
    localparam int ptr_w = $clog2(max_outstanding_p);
    localparam logic [ptr_w:0] ptr_one = 1;

    typedef enum logic [1:0] {E_READY, E_LO, E_HI} state_e;

    state_e state_reg, state_next;

    logic [hdr_width_p-1:0]  cmd_hdr_reg;
    logic [addr_width_p-1:0] cmd_addr_reg;
    logic [2:0]              cmd_size_reg;
    logic [63:0]             cmd_data_reg;
    logic                    cmd_split;

    logic                    cmd_ready;
    logic                    accept;
    logic                    hb_v;
    logic [addr_width_p-1:0] hb_addr;
    logic [2:0]              hb_size;
    logic [31:0]             hb_data;

    logic [max_outstanding_p-1:0] track_split_reg;
    logic [max_outstanding_p-1:0] track_wr_sel;
    logic [ptr_w:0]               wr_ptr_reg, rd_ptr_reg;
    logic                         track_empty, track_full, head_split;

    logic                    lo_valid_reg;
    logic [31:0]             lo_data_reg;
    logic [hdr_width_p-1:0]  lo_hdr_reg;
    logic [addr_width_p-1:0] lo_addr_reg;

    logic                    resp_v, resp_yumi, lo_capture, pop;
    logic [hdr_width_p-1:0]  resp_hdr;
    logic [addr_width_p-1:0] resp_addr;
    logic [2:0]              resp_size;
    logic [63:0]             resp_data;

    assign cmd_split   = (cmd_size_reg == 3'd3);
    assign accept      = bus.io_cmd_v_i & cmd_ready;
    assign track_empty = (wr_ptr_reg == rd_ptr_reg);
    assign track_full  = (wr_ptr_reg[ptr_w] != rd_ptr_reg[ptr_w]) &&
                         (wr_ptr_reg[ptr_w-1:0] == rd_ptr_reg[ptr_w-1:0]);
    assign head_split  = track_split_reg[rd_ptr_reg[ptr_w-1:0]];

    // Command FSM: state register and latched command.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg    <= E_READY;
            cmd_hdr_reg  <= '0;
            cmd_addr_reg <= '0;
            cmd_size_reg <= '0;
            cmd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cmd_hdr_reg  <= bus.io_cmd_hdr_i;
                cmd_addr_reg <= bus.io_cmd_addr_i;
                cmd_size_reg <= bus.io_cmd_size_i;
                cmd_data_reg <= bus.io_cmd_data_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        hb_v       = 1'b0;
        hb_addr    = cmd_addr_reg;
        hb_size    = cmd_size_reg;
        hb_data    = cmd_data_reg[31:0];
        case (state_reg)
            E_READY: begin
                cmd_ready = ~track_full;
                if (bus.io_cmd_v_i && !track_full) state_next = E_LO;
            end
            E_LO: begin
                hb_v = 1'b1;
                if (cmd_split) begin
                    hb_addr = {cmd_addr_reg[addr_width_p-1:3], 3'b000};
                    hb_size = 3'd2;
                end else if (cmd_addr_reg[2]) begin
                    hb_data = cmd_data_reg[63:32];
                end
                if (bus.hb_cmd_ready_and_i) state_next = cmd_split ? E_HI : E_READY;
            end
            E_HI: begin
                hb_v    = 1'b1;
                hb_addr = {cmd_addr_reg[addr_width_p-1:3], 3'b100};
                hb_size = 3'd2;
                hb_data = cmd_data_reg[63:32];
                if (bus.hb_cmd_ready_and_i) state_next = E_READY;
            end
            default: state_next = E_READY;
        endcase
        // Outputs are forced quiet while reset is held, whatever the state register holds.
        if (reset_i) begin
            cmd_ready = 1'b0;
            hb_v      = 1'b0;
        end
    end

    assign bus.io_cmd_ready_and_o = cmd_ready;
    assign bus.hb_cmd_v_o         = hb_v;
    assign bus.hb_cmd_hdr_o       = cmd_hdr_reg;
    assign bus.hb_cmd_addr_o      = hb_addr;
    assign bus.hb_cmd_size_o      = hb_size;
    assign bus.hb_cmd_data_o      = hb_data;

    // Tracking FIFO of split flags, one entry per in-flight upstream command.
    for (genvar gi = 0; gi < max_outstanding_p; gi++) begin : g_track_sel
        assign track_wr_sel[gi] = accept && (wr_ptr_reg[ptr_w-1:0] == ptr_w'(gi));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            track_split_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            for (int i = 0; i < max_outstanding_p; i++) begin
                if (track_wr_sel[i]) track_split_reg[i] <= (bus.io_cmd_size_i == 3'd3);
            end
            if (accept) wr_ptr_reg <= wr_ptr_reg + ptr_one;
            if (pop)    rd_ptr_reg <= rd_ptr_reg + ptr_one;
        end
    end

    // Response merge: first word of a split is parked, second word completes the message.
    always_comb begin
        resp_v     = 1'b0;
        resp_yumi  = 1'b0;
        lo_capture = 1'b0;
        resp_hdr   = bus.hb_resp_hdr_i;
        resp_addr  = bus.hb_resp_addr_i;
        resp_size  = bus.hb_resp_size_i;
        resp_data  = {2{bus.hb_resp_data_i}};
        if (!track_empty && !reset_i) begin
            if (head_split && !lo_valid_reg) begin
                resp_yumi  = bus.hb_resp_v_i;
                lo_capture = bus.hb_resp_v_i;
            end else begin
                resp_v    = bus.hb_resp_v_i;
                resp_yumi = bus.hb_resp_v_i & bus.io_resp_ready_and_i;
                if (head_split) begin
                    resp_hdr  = lo_hdr_reg;
                    resp_addr = lo_addr_reg;
                    resp_size = 3'd3;
                    resp_data = {bus.hb_resp_data_i, lo_data_reg};
                end
            end
        end
    end

    assign pop = resp_v & bus.io_resp_ready_and_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lo_valid_reg <= 1'b0;
            lo_data_reg  <= '0;
            lo_hdr_reg   <= '0;
            lo_addr_reg  <= '0;
        end else if (lo_capture) begin
            lo_valid_reg <= 1'b1;
            lo_data_reg  <= bus.hb_resp_data_i;
            lo_hdr_reg   <= bus.hb_resp_hdr_i;
            lo_addr_reg  <= bus.hb_resp_addr_i;
        end else if (pop) begin
            lo_valid_reg <= 1'b0;
        end
    end

    assign bus.hb_resp_yumi_o = resp_yumi;
    assign bus.io_resp_v_o    = resp_v;
    assign bus.io_resp_hdr_o  = resp_hdr;
    assign bus.io_resp_addr_o = resp_addr;
    assign bus.io_resp_size_o = resp_size;
    assign bus.io_resp_data_o = resp_data;

`ifdef BP_MMIO_SER_PERF_EN
    logic [31:0] split_cnt_reg;
    always_ff @(posedge clk_i) begin
        if (reset_i)                                  split_cnt_reg <= '0;
        else if (accept && bus.io_cmd_size_i == 3'd3) split_cnt_reg <= split_cnt_reg + 32'd1;
    end
    assign split_cnt_o = split_cnt_reg;
`endif

`ifndef SYNTHESIS
    // A word response with nothing in flight means the bridge is out of step with us.
    always_ff @(posedge clk_i) begin
        if (!reset_i && bus.hb_resp_v_i) assert (!track_empty);
    end
`endif
endmodule

// File: tb/tb_bp_mmio_dword_serializer.sv
// Bench for bp_mmio_dword_serializer: bridge model plus transaction-level reference queues.
module tb_bp_mmio_dword_serializer;
    localparam int AW = 40;
    localparam int HW = 16;

    typedef struct packed {
        logic [HW-1:0] hdr; logic [AW-1:0] addr; logic [2:0] size; logic [63:0] data;
    } cmd_t;
    typedef struct packed {
        logic [HW-1:0] hdr; logic [AW-1:0] addr; logic [2:0] size; logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    bp_mmio_dword_serializer_if #(.addr_width_p(AW), .hdr_width_p(HW)) bus ();
`ifdef BP_MMIO_SER_PERF_EN
    logic [31:0] split_cnt;
`endif

    bp_mmio_dword_serializer #(.addr_width_p(AW), .hdr_width_p(HW), .max_outstanding_p(4)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
`ifdef BP_MMIO_SER_PERF_EN
        ,
        .split_cnt_o (split_cnt)
`endif
    );

    int tests_run = 0, tests_failed = 0;
    int cyc = 0, n_accepts = 0, n_pops = 0, accept_cyc = 0, beat_cyc = 0;
    int cmd_pct = 0, hb_ready_pct = 0, resp_pct = 0, io_ready_pct = 0;
    bit rand_cmds = 0, have_cmd = 0, resp_hold = 0;
    cmd_t cur_cmd;
    cmd_t  cmd_q[$], fix_cmds[$];
    beat_t exp_beats[$], bq[$], beat_log[$];
    logic [31:0] words[$], fix_words[$];
    logic obs_cmd_ready, obs_hb_v, obs_io_v, obs_yumi, obs_accept, obs_beat, obs_pop;
    logic [63:0] obs_io_data, pop_data;
    logic [AW-1:0] pop_addr;
    logic [2:0] pop_size;

    function automatic bit chance(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        logic [63:0] r;
        r      = {$urandom, $urandom};
        c.hdr  = HW'($urandom);
        c.size = 3'($urandom_range(3));
        c.addr = (r[AW-1:0] >> c.size) << c.size;
        c.data = {$urandom, $urandom};
        return c;
    endfunction

    function automatic cmd_t mk_cmd(input logic [HW-1:0] h, input logic [AW-1:0] a,
                                    input logic [2:0] s, input logic [63:0] d);
        cmd_t c;
        c.hdr = h; c.addr = a; c.size = s; c.data = d;
        return c;
    endfunction

    // One clock of the whole environment: core source, bridge model, response sink.
    task automatic step(input bit rst);
        beat_t b, e;
        cmd_t c;
        logic [31:0] w0, w1;
        logic [63:0] ed;
        logic [AW-1:0] ea;
        logic [2:0] es;
        @(negedge clk);
        cyc++;
        reset_i = rst;
        if (!have_cmd) begin
            if (fix_cmds.size() > 0) begin cur_cmd = fix_cmds.pop_front(); have_cmd = 1; end
            else if (rand_cmds && chance(cmd_pct)) begin cur_cmd = rand_cmd(); have_cmd = 1; end
        end
        bus.io_cmd_v_i    = have_cmd;
        bus.io_cmd_hdr_i  = cur_cmd.hdr;
        bus.io_cmd_addr_i = cur_cmd.addr;
        bus.io_cmd_size_i = cur_cmd.size;
        bus.io_cmd_data_i = cur_cmd.data;
        bus.hb_cmd_ready_and_i = chance(hb_ready_pct);
        if (!resp_hold && bq.size() > 0 && chance(resp_pct)) resp_hold = 1;
        bus.hb_resp_v_i = resp_hold;
        if (resp_hold) begin
            bus.hb_resp_hdr_i  = bq[0].hdr;
            bus.hb_resp_addr_i = bq[0].addr;
            bus.hb_resp_size_i = bq[0].size;
            bus.hb_resp_data_i = bq[0].data;
        end
        bus.io_resp_ready_and_i = chance(io_ready_pct);
        #1;
        obs_cmd_ready = bus.io_cmd_ready_and_o;
        obs_hb_v      = bus.hb_cmd_v_o;
        obs_io_v      = bus.io_resp_v_o;
        obs_yumi      = bus.hb_resp_yumi_o;
        obs_io_data   = bus.io_resp_data_o;
        obs_accept = 0; obs_beat = 0; obs_pop = 0;
        if (rst) begin
            cmd_q.delete(); exp_beats.delete(); bq.delete(); words.delete();
            have_cmd = 0; resp_hold = 0;
            return;
        end
        if (bus.io_cmd_v_i && obs_cmd_ready) begin
            obs_accept = 1; n_accepts++; accept_cyc = cyc;
            cmd_q.push_back(cur_cmd);
            if (cur_cmd.size == 3'd3) begin
                exp_beats.push_back({cur_cmd.hdr, {cur_cmd.addr[AW-1:3], 3'b000}, 3'd2, cur_cmd.data[31:0]});
                exp_beats.push_back({cur_cmd.hdr, {cur_cmd.addr[AW-1:3], 3'b100}, 3'd2, cur_cmd.data[63:32]});
            end else begin
                exp_beats.push_back({cur_cmd.hdr, cur_cmd.addr, cur_cmd.size,
                                     cur_cmd.addr[2] ? cur_cmd.data[63:32] : cur_cmd.data[31:0]});
            end
            have_cmd = 0;
        end
        if (obs_hb_v && bus.hb_cmd_ready_and_i) begin
            obs_beat = 1; beat_cyc = cyc;
            b = {bus.hb_cmd_hdr_o, bus.hb_cmd_addr_o, bus.hb_cmd_size_o, bus.hb_cmd_data_o};
            beat_log.push_back(b);
            tests_run++;
            if (exp_beats.size() == 0) begin
                tests_failed++;
                $display("FAIL hb_beat_unexpected got=%h required=none", b);
            end else begin
                e = exp_beats.pop_front();
                if (b !== e) begin
                    tests_failed++;
                    $display("FAIL hb_beat got=%h required=%h", b, e);
                end
            end
            if (fix_words.size() > 0) w0 = fix_words.pop_front();
            else w0 = $urandom;
            bq.push_back({b.hdr, b.addr, b.size, w0});
            words.push_back(w0);
        end
        if (obs_io_v) begin
            tests_run++;
            if (!bus.hb_resp_v_i) begin
                tests_failed++;
                $display("FAIL io_resp_v_without_word got=1 required=0");
            end
        end
        if (obs_yumi) begin
            tests_run++;
            if (!resp_hold) begin
                tests_failed++;
                $display("FAIL yumi_without_valid got=1 required=0");
            end else begin
                void'(bq.pop_front());
                resp_hold = 0;
            end
        end
        if (obs_io_v && bus.io_resp_ready_and_i) begin
            obs_pop = 1; n_pops++;
            pop_data = obs_io_data; pop_addr = bus.io_resp_addr_o; pop_size = bus.io_resp_size_o;
            tests_run++;
            if (cmd_q.size() == 0 || words.size() == 0) begin
                tests_failed++;
                $display("FAIL io_resp_unexpected got=%h required=none", obs_io_data);
            end else begin
                c = cmd_q.pop_front();
                w0 = words.pop_front();
                if (c.size == 3'd3) begin
                    w1 = (words.size() > 0) ? words.pop_front() : 32'hx;
                    ed = {w1, w0}; ea = {c.addr[AW-1:3], 3'b000}; es = 3'd3;
                end else begin
                    ed = {w0, w0}; ea = c.addr; es = c.size;
                end
                if ({bus.io_resp_hdr_o, pop_addr, pop_size, pop_data} !== {c.hdr, ea, es, ed}) begin
                    tests_failed++;
                    $display("FAIL io_resp got=%h/%h/%0d/%h required=%h/%h/%0d/%h",
                             bus.io_resp_hdr_o, pop_addr, pop_size, pop_data, c.hdr, ea, es, ed);
                end
            end
            $display("[TB] cyc %0d io_resp addr=%h size=%0d data=%h", cyc, pop_addr, pop_size, pop_data);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        rand_cmds = 0; hb_ready_pct = 100; resp_pct = 100; io_ready_pct = 100;
        while ((have_cmd || fix_cmds.size() > 0 || cmd_q.size() > 0) && n < budget) begin
            step(0); n++;
        end
        tests_run++;
        if (have_cmd || cmd_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain_timeout got=%0d_outstanding required=0", cmd_q.size());
        end
    endtask

    task automatic wait_pop(input int budget, input string name);
        int n = 0;
        do begin step(0); n++; end while (!obs_pop && n < budget);
        tests_run++;
        if (!obs_pop) begin
            tests_failed++;
            $display("FAIL %s_timeout got=no_resp required=resp", name);
        end
    endtask

    task automatic test_reset();
        step(1);
        tests_run++;
        if ({obs_cmd_ready, obs_hb_v, obs_io_v, obs_yumi} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b required=0000", {obs_cmd_ready, obs_hb_v, obs_io_v, obs_yumi});
        end
        step(1);
        step(0);
        tests_run++;
        if ({obs_cmd_ready, obs_hb_v, obs_io_v, obs_yumi} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL post_reset_idle got=%b required=1000", {obs_cmd_ready, obs_hb_v, obs_io_v, obs_yumi});
        end
    endtask

    task automatic test_single_read();
        beat_log.delete();
        hb_ready_pct = 100; resp_pct = 100; io_ready_pct = 100;
        fix_cmds.push_back(mk_cmd(16'h00A5, 40'h00_1000_0004, 3'd2, 64'h0));
        fix_words.push_back(32'hDEAD_BEEF);
        wait_pop(20, "single_read");
        tests_run++;
        if (beat_log.size() != 1 || beat_log[0].addr !== 40'h00_1000_0004 || beat_log[0].size !== 3'd2) begin
            tests_failed++;
            $display("FAIL single_beat got=%0d_beats addr=%h required=1_beat addr=0010000004", beat_log.size(),
                     (beat_log.size() > 0) ? beat_log[0].addr : 40'h0);
        end
        tests_run++;
        if (beat_cyc != accept_cyc + 1) begin
            tests_failed++;
            $display("FAIL cmd_latency got=%0d required=1", beat_cyc - accept_cyc);
        end
        tests_run++;
        if (pop_data !== 64'hDEAD_BEEF_DEAD_BEEF || pop_size !== 3'd2) begin
            tests_failed++;
            $display("FAIL single_resp got=%h/%0d required=deadbeefdeadbeef/2", pop_data, pop_size);
        end
    endtask

    task automatic test_split_write();
        beat_log.delete();
        hb_ready_pct = 100; resp_pct = 100; io_ready_pct = 100;
        fix_cmds.push_back(mk_cmd(16'h1234, 40'h00_1000_0008, 3'd3, 64'h1122_3344_5566_7788));
        wait_pop(20, "split_write");
        tests_run++;
        if (beat_log.size() != 2 ||
            {beat_log[0].addr, beat_log[0].data} !== {40'h00_1000_0008, 32'h5566_7788} ||
            {beat_log[1].addr, beat_log[1].data} !== {40'h00_1000_000C, 32'h1122_3344}) begin
            tests_failed++;
            $display("FAIL split_beats got=%0d_beats required=2_beats 08/55667788 0C/11223344", beat_log.size());
        end
        tests_run++;
        if (pop_addr !== 40'h00_1000_0008 || pop_size !== 3'd3) begin
            tests_failed++;
            $display("FAIL split_merge got=%h/%0d required=0010000008/3", pop_addr, pop_size);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        hb_ready_pct = 100; resp_pct = 100; io_ready_pct = 0;
        fix_cmds.push_back(mk_cmd(16'h0042, 40'h00_1000_0010, 3'd3, 64'h0));
        fix_words.push_back(32'hAAAA_0000);
        fix_words.push_back(32'hBBBB_1111);
        do begin step(0); n++; end while (!obs_io_v && n < 20);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({obs_io_v, obs_yumi, obs_io_data} !== {2'b10, 64'hBBBB_1111_AAAA_0000}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d got=v%b y%b %h required=v1 y0 bbbb1111aaaa0000",
                         i, obs_io_v, obs_yumi, obs_io_data);
            end
            step(0);
        end
        drain(50);
    endtask

    task automatic test_full();
        int base = n_accepts;
        hb_ready_pct = 100; resp_pct = 0; io_ready_pct = 100;
        for (int i = 0; i < 5; i++) fix_cmds.push_back(mk_cmd(HW'(i), 40'h00_2000_0000 + 40'(i * 4), 3'd2, 64'h0));
        for (int i = 0; i < 16; i++) step(0);
        tests_run++;
        if (n_accepts - base != 4 || obs_cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_block got=%0d_accepts ready=%b required=4_accepts ready=0", n_accepts - base, obs_cmd_ready);
        end
        resp_pct = 100;
        wait_pop(10, "full_release");
        tests_run++;
        if (obs_cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_no_bypass got=%b required=0", obs_cmd_ready);
        end
        step(0);
        tests_run++;
        if (obs_cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_ready_after_pop got=%b required=1", obs_cmd_ready);
        end
        drain(100);
    endtask

    task automatic test_reset_mid();
        int n = 0, base;
        hb_ready_pct = 100; resp_pct = 100; io_ready_pct = 100;
        fix_cmds.push_back(mk_cmd(16'h0077, 40'h00_1000_0020, 3'd3, 64'h0));
        do begin step(0); n++; end while (!obs_beat && n < 10);
        hb_ready_pct = 0;
        step(0);
        step(0);
        tests_run++;
        if ({obs_hb_v, obs_io_v} !== 2'b10) begin
            tests_failed++;
            $display("FAIL mid_hi_state got=%b required=10", {obs_hb_v, obs_io_v});
        end
        step(1);
        step(0);
        tests_run++;
        if ({obs_cmd_ready, obs_hb_v, obs_io_v, obs_yumi} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mid_reset_flush got=%b required=1000", {obs_cmd_ready, obs_hb_v, obs_io_v, obs_yumi});
        end
        base = n_pops;
        fix_cmds.push_back(mk_cmd(16'h0078, 40'h00_1000_0024, 3'd2, 64'h0));
        drain(50);
        tests_run++;
        if (n_pops - base != 1) begin
            tests_failed++;
            $display("FAIL mid_reset_recover got=%0d required=1", n_pops - base);
        end
    endtask

    task automatic test_random();
        int n = 0, a0 = n_accepts, p0 = n_pops;
        rand_cmds = 1; cmd_pct = 60; hb_ready_pct = 70; resp_pct = 60; io_ready_pct = 70;
        while (n_accepts - a0 < 200 && n < 6000) begin step(0); n++; end
        drain(2000);
        tests_run++;
        if (n_pops - p0 != n_accepts - a0 || n_accepts - a0 < 200) begin
            tests_failed++;
            $display("FAIL random_count got=%0d_resps required=%0d_accepts(>=200)", n_pops - p0, n_accepts - a0);
        end
    endtask

`ifdef BP_MMIO_SER_PERF_EN
    task automatic test_perf();
        step(1);
        for (int i = 0; i < 5; i++)
            fix_cmds.push_back(mk_cmd(HW'(i), 40'h00_3000_0000 + 40'(i * 8), (i % 2 == 0) ? 3'd3 : 3'd2, 64'h0));
        drain(100);
        tests_run++;
        if (split_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL perf_split_cnt got=%0d required=3", split_cnt);
        end
    endtask
`endif

    initial begin
        reset_i = 1'b1;
        bus.io_cmd_v_i = 0; bus.io_cmd_hdr_i = '0; bus.io_cmd_addr_i = '0;
        bus.io_cmd_size_i = '0; bus.io_cmd_data_i = '0;
        bus.hb_cmd_ready_and_i = 0;
        bus.hb_resp_v_i = 0; bus.hb_resp_hdr_i = '0; bus.hb_resp_addr_i = '0;
        bus.hb_resp_size_i = '0; bus.hb_resp_data_i = '0;
        bus.io_resp_ready_and_i = 0;
        cur_cmd = '0;
        test_reset();
        test_single_read();
        test_split_write();
        test_stall();
        test_full();
        test_reset_mid();
        test_random();
`ifdef BP_MMIO_SER_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
